perf_monitor: RTL and testbench

PERF_MONITOR -- requirements
Module: perf_monitor

---
 rtl/perf_monitor_if.sv | 31 +++
 rtl/perf_monitor.sv | 136 +++++++++++++
 tb/tb_perf_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/perf_monitor_if.sv
// Bundles the control, event, readback and status signals of perf_monitor.
// The monitor itself connects through the slave view; a host or driver uses master.
interface perf_monitor_if #(
   parameter int NCH = 4,
   parameter int CW  = 32,
   parameter int PCW = 16
);
   logic           start;
   logic           stop;
   logic           clear;
   logic [NCH-1:0] event_in;
   logic [PCW-1:0] pc;
   logic           snap_req;
   logic [3:0]     rd_sel;
   logic [CW-1:0]  rd_data;
   logic [CW-1:0]  cycle_count;
   logic [PCW-1:0] final_pc;
   logic [NCH-1:0] ovf;
   logic [1:0]     state;
   logic           done;

   modport master (
      output start, stop, clear, event_in, pc, snap_req, rd_sel,
      input  rd_data, cycle_count, final_pc, ovf, state, done
   );

   modport slave (
      input  start, stop, clear, event_in, pc, snap_req, rd_sel,
      output rd_data, cycle_count, final_pc, ovf, state, done
   );
endinterface

// File: rtl/perf_monitor.sv
// Performance monitor: NCH saturating event counters, a run-length cycle counter,
// a shadow snapshot bank, and final-PC capture, all sequenced by an IDLE/RUN/HALT FSM.
// A MAX_CYCLES value that does not fit in CW bits never matches the cycle counter,
// so no timeout occurs; the cycle counter then holds at all-ones once it gets there.
module perf_monitor #(
   parameter int NCH        = 4,
   parameter int CW         = 32,
   parameter int PCW        = 16,
   parameter int MAX_CYCLES = 5000
) (
   input  logic          clk,
   input  logic          rst,
   perf_monitor_if.slave bus
);

   localparam logic [1:0]    ST_IDLE = 2'd0;
   localparam logic [1:0]    ST_RUN  = 2'd1;
   localparam logic [1:0]    ST_HALT = 2'd2;
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [32:0]   MAX_W   = 33'(MAX_CYCLES);

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  cycle_q, cycle_d;
   logic [PCW-1:0] final_pc_q, final_pc_d;
   logic [NCH-1:0] ovf_q, ovf_d;
   logic [CW-1:0]  cnt_q    [NCH];
   logic [CW-1:0]  cnt_d    [NCH];
   logic [CW-1:0]  shadow_q [NCH];
   logic [CW-1:0]  shadow_d [NCH];
   logic [CW-1:0]  rd_data_q, rd_data_d;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CW'(1);
   endfunction

   // FSM sequencing plus counter, snapshot, overflow and final-PC next-state logic
   always_comb begin
      state_d    = state_q;
      cycle_d    = cycle_q;
      final_pc_d = final_pc_q;
      ovf_d      = ovf_q;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i]    = cnt_q[i];
         shadow_d[i] = shadow_q[i];
      end

      if (bus.clear) begin
         // clear beats start, stop and timeout
         state_d    = ST_IDLE;
         cycle_d    = '0;
         final_pc_d = '0;
         ovf_d      = '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_d[i]    = '0;
            shadow_d[i] = '0;
         end
      end else begin
         case (state_q)
            ST_IDLE, ST_HALT: begin
               if (bus.start) begin
                  // a new run starts from a clean slate; final_pc is kept until next halt
                  state_d = ST_RUN;
                  cycle_d = '0;
                  ovf_d   = '0;
                  for (int i = 0; i < NCH; i++) begin
                     cnt_d[i]    = '0;
                     shadow_d[i] = '0;
                  end
               end
            end
            ST_RUN: begin
               cycle_d = sat_inc(cycle_q);
               for (int i = 0; i < NCH; i++) begin
                  if (bus.event_in[i]) begin
                     if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
                     cnt_d[i] = sat_inc(cnt_q[i]);
                  end
               end
               // snapshot holds the values including this edge's increments
               if (bus.snap_req) begin
                  for (int i = 0; i < NCH; i++) shadow_d[i] = cnt_d[i];
               end
               // stop and timeout together are just one halt
               if (bus.stop || (33'(cycle_d) == MAX_W)) begin
                  state_d    = ST_HALT;
                  final_pc_d = bus.pc;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Readback mux: shadow bank while running, live counters otherwise, zero when out of range
   always_comb begin
      rd_data_d = '0;
      for (int i = 0; i < NCH; i++) begin
         if (bus.rd_sel == 4'(i)) begin
            rd_data_d = (state_q == ST_RUN) ? shadow_q[i] : cnt_q[i];
         end
      end
   end

   // State registers with asynchronous reset that abandons any run in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cycle_q    <= '0;
         final_pc_q <= '0;
         ovf_q      <= '0;
         rd_data_q  <= '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i]    <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         cycle_q    <= cycle_d;
         final_pc_q <= final_pc_d;
         ovf_q      <= ovf_d;
         rd_data_q  <= rd_data_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i]    <= cnt_d[i];
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign bus.state       = state_q;
   assign bus.done        = (state_q == ST_HALT);
   assign bus.cycle_count = cycle_q;
   assign bus.final_pc    = final_pc_q;
   assign bus.ovf         = ovf_q;
   assign bus.rd_data     = rd_data_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: a default-parameter instance and a CW=8 instance.
module tb_perf_monitor;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   perf_monitor_if #(.NCH(4), .CW(32), .PCW(16)) bus ();
   perf_monitor_if #(.NCH(4), .CW(8),  .PCW(16)) bus8 ();

   perf_monitor #(.NCH(4), .CW(32), .PCW(16), .MAX_CYCLES(5000)) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   perf_monitor #(.NCH(4), .CW(8), .PCW(16), .MAX_CYCLES(5000)) u_dut8 (
      .clk(clk), .rst(rst), .bus(bus8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // advance one rising edge, then settle 1ns past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int steps;
      bus.start = 0; bus.stop = 0; bus.clear = 0; bus.event_in = '0;
      bus.pc = '0; bus.snap_req = 0; bus.rd_sel = '0;
      bus8.start = 0; bus8.stop = 0; bus8.clear = 0; bus8.event_in = '0;
      bus8.pc = '0; bus8.snap_req = 0; bus8.rd_sel = '0;

      // reset state
      step(); step();
      check("rst_state", bus.state, 0);
      check("rst_done", bus.done, 0);
      check("rst_cycle", bus.cycle_count, 0);
      check("rst_rd", bus.rd_data, 0);
      check("rst_ovf", bus.ovf, 0);
      rst = 0;
      step();

      // early stop: 10 RUN cycles, then stop with event_in[1] on the stop cycle only
      bus.start = 1; step(); bus.start = 0;
      check("es_state_run", bus.state, 1);
      check("es_cycle0", bus.cycle_count, 0);
      repeat (10) step();
      check("es_cycle10", bus.cycle_count, 10);
      bus.stop = 1; bus.event_in = 4'b0010; bus.pc = 16'h1234;
      step();
      bus.stop = 0; bus.event_in = '0;
      check("es_state_halt", bus.state, 2);
      check("es_done", bus.done, 1);
      check("es_cycle11", bus.cycle_count, 11);
      check("es_final_pc", bus.final_pc, 16'h1234);
      bus.rd_sel = 4'd1; step();
      check("es_ch1", bus.rd_data, 1);

      // frozen in HALT: events and stop ignored
      bus.event_in = 4'b1111; bus.stop = 1; bus.pc = 16'h5555;
      repeat (3) step();
      bus.event_in = '0; bus.stop = 0;
      check("frz_cycle", bus.cycle_count, 11);
      check("frz_ch1", bus.rd_data, 1);
      check("frz_final_pc", bus.final_pc, 16'h1234);
      bus.rd_sel = 4'd5; step();
      check("rd_oob", bus.rd_data, 0);

      // clear beats start in HALT
      bus.clear = 1; bus.start = 1; step();
      bus.clear = 0; bus.start = 0;
      check("clr_state", bus.state, 0);
      check("clr_cycle", bus.cycle_count, 0);
      check("clr_final_pc", bus.final_pc, 0);
      bus.rd_sel = 4'd1; step();
      check("clr_ch1", bus.rd_data, 0);

      // snapshot at RUN cycle 7 with event_in[3] held; start ignored while running
      bus.start = 1; step(); bus.start = 0;
      bus.event_in = 4'b1000;
      step(); step();
      bus.start = 1; step(); step(); bus.start = 0;
      step(); step();
      bus.snap_req = 1; step(); bus.snap_req = 0;
      check("snap_cycle7", bus.cycle_count, 7);
      bus.rd_sel = 4'd3; step();
      check("snap_rd", bus.rd_data, 7);
      check("snap_live_cycle", bus.cycle_count, 8);
      bus.stop = 1; step(); bus.stop = 0; bus.event_in = '0;
      check("snap_halt_cycle", bus.cycle_count, 9);
      step();
      check("snap_live_ch3", bus.rd_data, 9);

      // timeout at MAX_CYCLES with event_in[0] held, pc changing every cycle
      bus.start = 1; step(); bus.start = 0;
      bus.event_in = 4'b0001;
      steps = 0;
      while (bus.state == 2'd1 && steps < 6000) begin
         steps++;
         bus.pc = 16'(steps);
         step();
      end
      bus.event_in = '0;
      check("to_steps", steps, 5000);
      check("to_state", bus.state, 2);
      check("to_cycle", bus.cycle_count, 5000);
      check("to_final_pc", bus.final_pc, 5000);
      bus.rd_sel = 4'd0; step();
      check("to_ch0", bus.rd_data, 5000);
      check("to_ovf", bus.ovf, 0);

      // saturation on the 8-bit instance: 300 RUN cycles of event_in[2]
      bus8.start = 1; step(); bus8.start = 0;
      bus8.event_in = 4'b0100;
      repeat (255) step();
      check("sat_ovf_at_max", bus8.ovf, 4'b0000);
      repeat (45) step();
      check("sat_state_run", bus8.state, 1);
      check("sat_cycle", bus8.cycle_count, 255);
      check("sat_ovf", bus8.ovf, 4'b0100);
      bus8.stop = 1; step(); bus8.stop = 0; bus8.event_in = '0;
      bus8.rd_sel = 4'd2; step();
      check("sat_ch2", bus8.rd_data, 255);
      check("sat_ovf_sticky", bus8.ovf, 4'b0100);
      bus8.start = 1; step(); bus8.start = 0;
      check("sat_ovf_restart", bus8.ovf, 4'b0000);

      // asynchronous reset between edges in the middle of a run
      bus.start = 1; step(); bus.start = 0;
      bus.event_in = 4'b1111; bus.pc = 16'hAAAA;
      repeat (5) step();
      #2 rst = 1;
      #1;
      check("ar_state", bus.state, 0);
      check("ar_done", bus.done, 0);
      check("ar_cycle", bus.cycle_count, 0);
      check("ar_final_pc", bus.final_pc, 0);
      check("ar_ovf", bus.ovf, 0);
      check("ar_rd", bus.rd_data, 0);
      #1 rst = 0;
      bus.event_in = '0;
      bus.start = 1; step(); bus.start = 0;
      check("ar_resume_state", bus.state, 1);
      step();
      check("ar_resume_cycle", bus.cycle_count, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
